mu0_scan_ctrl: RTL
==================

Name: mu0_scan_ctrl

Overview:
Scan-path master for the MU0 register scanner. On a debugger request it generates scan_clk and scan_en for the scanner, then serially samples its scan_out bit stream. It captures accumulator, PC and flags into a parallel snapshot and presents that snapshot under a valid/ack handshake. The block sits in the FPGA debug wrapper between the debugger-side logic and the scanner, and runs entirely on the system clock.

Parameters:
HALF_PERIOD, 2, clk cycles per scan_clk phase (low or high); legal range >= 1.
CNT_W, 8, width of the phase-timer counter; must hold HALF_PERIOD-1.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset
req  input  1  level; requests a snapshot, sampled only in IDLE
ack  input  1  consumes the snapshot, sampled only in DONE
scan_out  input  1  serial bit from the scanner
scan_clk  output  1  registered scan-path clock to the scanner
scan_en  output  1  registered scan enable to the scanner
busy  output  1  high in every state except IDLE
snap_valid  output  1  high in DONE
snap_acc  output  16  captured accumulator
snap_pc  output  12  captured program counter
snap_flags  output  2  captured flags

Behaviour:
- Reset (rst_n low at an edge): state IDLE. scan_clk=0, scan_en=0, busy=0, snap_valid=0, all snap_* = 0, bit counter and phase timer = 0. Reset mid-scan aborts immediately with no partial snapshot.
- Scanner protocol: a scan_clk rise with scan_en=0 zeroes the scanner bit index. Each rise with scan_en=1 advances the index (0..29, then wrap). scan_out is combinational on the index. Bit order: 0-15 acc[0..15], 16-27 pc[0..11], 28-29 flags[0..1].
- Every non-IDLE/DONE state lasts exactly HALF_PERIOD clk cycles, timed by the phase timer.
- States and outputs:
  - IDLE: clk_s=0, en=0. If req=1, go to RST_LO.
  - RST_LO: clk_s=0, en=0. Go to RST_HI.
  - RST_HI: clk_s=1, en=0. This rise resynchronises the scanner to index 0. Go to SH_LO.
  - SH_LO: clk_s=0, en=1. On the final cycle, scan_out is written into capture bit [bitcnt]. Go to SH_HI.
  - SH_HI: clk_s=1, en=1. If bitcnt=29, copy capture to snap_*, set bitcnt=0 and go to DONE. Otherwise increment bitcnt and go to SH_LO.
  - DONE: clk_s=0, en=0, snap_valid=1. If ack=1, go to IDLE.
- scan_clk and scan_en are driven directly from state registers, with no combinational glitches. Any edge on which scan_clk falls and scan_en changes together is legal.
- Latency: let req be sampled high in IDLE at edge E0. Then snap_valid=1 after edge E0 + 62*HALF_PERIOD, i.e. 124 cycles at the default. Each scan emits exactly 31 scan_clk rising edges.
- snap_* change only at the SH_HI->DONE edge and hold their value through DONE, IDLE and the next scan.
- req during busy is ignored; ack outside DONE is ignored. If req is still high on the first IDLE cycle after ack, a new scan starts (back-to-back).
- snap_valid falls on the edge that samples ack=1 in DONE. busy falls on that same edge.
- bitcnt is 5 bits, range 0..29, and never exceeds 29.

Decomposition:
- Package mu0_scan_pkg: ACC_W=16, PC_W=12, FLAGS_W=2, SCAN_LEN=30 (= sum of the three widths), BITCNT_W=5, state enum {IDLE, RST_LO, RST_HI, SH_LO, SH_HI, DONE}.
- One sub-module, mu0_scan_phase_timer: a CNT_W-bit down-counter. It reloads HALF_PERIOD-1 on a state change and asserts phase_end when the count reaches 0.

Test Plan:
- Setup for all scenarios: a behavioural scanner model is connected to scan_clk, scan_en and scan_out.
- Basic: acc=16'hA5C3, pc=12'h123, flags=2'b10, HALF_PERIOD=2, req pulsed for one cycle -> snap_valid rises exactly 124 clk after acceptance. Expect 31 scan_clk rises, with scan_en=0 on the first rise only. snap_acc=A5C3, snap_pc=123, snap_flags=2.
- Hold/handshake: withhold ack for 50 cycles and toggle req -> snap_valid and snap_* stay stable and no scan_clk edges occur. Pulse ack -> snap_valid=0 and busy=0 on the next edge.
- Back-to-back: req held high, inputs changed to acc=16'hFFFF, pc=12'h000, flags=2'b01 before the first ack -> second scan starts on the first IDLE cycle. After the first ack, snap_* still show A5C3/123/2 until the second DONE, then FFFF/000/1.
- Reset mid-scan: rst_n=0 during SH_LO of bit 10 -> after that edge, scan_clk=0, scan_en=0, busy=0, snap_valid=0, snap_*=0. The next req yields a correct snapshot, even though the scanner index was left at 10.
- HALF_PERIOD=1: same values as Basic -> snap_valid after exactly 62 cycles. Each scan_clk high and low phase lasts 1 cycle.
- Spurious ack: ack=1 held during IDLE and during the scan -> no effect on the scan. DONE exits on the first edge after entry only because ack is still high, giving snap_valid high for exactly 1 cycle.

Source files
------------

// File: rtl/mu0_scan_ctrl_pkg.sv
// Shared definitions for the MU0 scan-path master: field widths of the
// scanned register word, the controller state encoding, the snapshot
// record and a helper that splits a captured word into its fields.
package mu0_scan_pkg;

  // Widths of the three register fields carried on the scan path
  localparam int ACC_W   = 16;
  localparam int PC_W    = 12;
  localparam int FLAGS_W = 2;

  // Total serial word length and the counter that walks it
  localparam int SCAN_LEN = ACC_W + PC_W + FLAGS_W;
  localparam int BITCNT_W = 5;

  // Index of the last serial bit; the bit counter wraps back to 0 after it
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(SCAN_LEN - 1);

  // Controller states
  //   IDLE   : waiting for a request
  //   RST_LO : scan_clk low, scan_en low, ahead of the resync rise
  //   RST_HI : scan_clk high with scan_en low, zeroes the scanner index
  //   SH_LO  : scan_clk low, scan_en high, bit sampled at end of phase
  //   SH_HI  : scan_clk high, scan_en high, scanner advances its index
  //   DONE   : snapshot valid, waiting for ack
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST_LO = 3'd1,
    RST_HI = 3'd2,
    SH_LO  = 3'd3,
    SH_HI  = 3'd4,
    DONE   = 3'd5
  } scan_state_t;

  // Parallel snapshot of the scanned registers
  typedef struct packed {
    logic [FLAGS_W-1:0] flags;
    logic [PC_W-1:0]    pc;
    logic [ACC_W-1:0]   acc;
  } snap_t;

  // Split a captured serial word into its fields. Serial bit order is
  // acc[0..15], then pc[0..11], then flags[0..1], so bit 0 of the word
  // is the first bit shifted out of the scanner.
  function automatic snap_t unpack_capture(input logic [SCAN_LEN-1:0] cap);
    snap_t s;
    s.acc   = cap[ACC_W-1:0];
    s.pc    = cap[ACC_W+PC_W-1:ACC_W];
    s.flags = cap[SCAN_LEN-1:ACC_W+PC_W];
    return s;
  endfunction

endpackage

// File: rtl/mu0_scan_ctrl_if.sv
// Debugger-side handshake bundle of the scan-path master: request/ack,
// status flags and the parallel snapshot. The master modport is the
// debugger logic, the slave modport is the scan controller.
interface mu0_scan_ctrl_if;
  import mu0_scan_pkg::*;

  logic               req;
  logic               ack;
  logic               busy;
  logic               snap_valid;
  logic [ACC_W-1:0]   snap_acc;
  logic [PC_W-1:0]    snap_pc;
  logic [FLAGS_W-1:0] snap_flags;

  modport master (
    output req,
    output ack,
    input  busy,
    input  snap_valid,
    input  snap_acc,
    input  snap_pc,
    input  snap_flags
  );

  modport slave (
    input  req,
    input  ack,
    output busy,
    output snap_valid,
    output snap_acc,
    output snap_pc,
    output snap_flags
  );

endinterface

// File: rtl/mu0_scan_ctrl_phase_timer.sv
// Phase timer for the scan controller. A down-counter that reloads
// HALF_PERIOD-1 whenever the controller changes state, so every timed
// state lasts exactly HALF_PERIOD clk cycles; phase_end marks the last
// cycle of the current phase.
module mu0_scan_phase_timer #(
  parameter int HALF_PERIOD = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic phase_end
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Reload on a state change, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign phase_end = (count == '0);

endmodule

// File: rtl/mu0_scan_ctrl.sv
// MU0 scan-path master. On a debugger request it drives scan_clk and
// scan_en to the register scanner, first with one rise at scan_en=0 to
// resynchronise the scanner to bit 0, then 30 rises at scan_en=1 while
// sampling scan_out at the end of each low phase. The captured word is
// presented as a parallel snapshot under a valid/ack handshake.
module mu0_scan_ctrl
  import mu0_scan_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mu0_scan_ctrl_if.slave   dbg,
  input  logic             scan_out,
  output logic             scan_clk,
  output logic             scan_en
);

  scan_state_t           state;
  scan_state_t           next_state;
  logic                  next_scan_clk;
  logic                  next_scan_en;
  logic                  phase_end;
  logic                  state_change;
  logic [BITCNT_W-1:0]   bitcnt;
  logic [SCAN_LEN-1:0]   capture;
  snap_t                 snap;
  logic                  sample_bit;
  logic                  bit_done;
  logic                  last_bit_done;

  // A new phase starts whenever the state moves, which restarts the timer
  assign state_change = (next_state != state);

  mu0_scan_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_change),
    .phase_end (phase_end)
  );

  // Qualified phase-end strobes used by the datapath
  assign sample_bit    = (state == SH_LO) && phase_end;
  assign bit_done      = (state == SH_HI) && phase_end;
  assign last_bit_done = bit_done && (bitcnt == LAST_BIT);

  // State register; scan_clk/scan_en are registered alongside it so the
  // scanner never sees a combinational glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      scan_clk <= 1'b0;
      scan_en  <= 1'b0;
    end else begin
      state    <= next_state;
      scan_clk <= next_scan_clk;
      scan_en  <= next_scan_en;
    end
  end

  // Next-state logic: timed states advance on phase_end, IDLE and DONE
  // wait for the handshake inputs
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (dbg.req) next_state = RST_LO;
      end
      RST_LO: begin
        if (phase_end) next_state = RST_HI;
      end
      RST_HI: begin
        if (phase_end) next_state = SH_LO;
      end
      SH_LO: begin
        if (phase_end) next_state = SH_HI;
      end
      SH_HI: begin
        if (phase_end) next_state = (bitcnt == LAST_BIT) ? DONE : SH_LO;
      end
      DONE: begin
        if (dbg.ack) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Scan-path output decode from the state being entered, so the
  // registered outputs line up with the state register
  always_comb begin
    next_scan_clk = 1'b0;
    next_scan_en  = 1'b0;
    case (next_state)
      RST_HI: begin
        next_scan_clk = 1'b1;
      end
      SH_LO: begin
        next_scan_en = 1'b1;
      end
      SH_HI: begin
        next_scan_clk = 1'b1;
        next_scan_en  = 1'b1;
      end
      default: begin
        next_scan_clk = 1'b0;
        next_scan_en  = 1'b0;
      end
    endcase
  end

  // Serial capture: sample scan_out on the last cycle of each low phase
  // and step the bit counter at the end of each high phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitcnt  <= '0;
      capture <= '0;
    end else begin
      if (sample_bit) begin
        capture[bitcnt] <= scan_out;
      end
      if (bit_done) begin
        bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
      end
    end
  end

  // Snapshot register: updated only when the final bit completes, so an
  // aborted scan never leaves a partial snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (last_bit_done) begin
      snap <= unpack_capture(capture);
    end
  end

  assign dbg.busy       = (state != IDLE);
  assign dbg.snap_valid = (state == DONE);
  assign dbg.snap_acc   = snap.acc;
  assign dbg.snap_pc    = snap.pc;
  assign dbg.snap_flags = snap.flags;

endmodule
